// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency counter gate controller.
package freq_counter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        GATE = 3'd2,
        WAIT = 3'd3,
        EVAL = 3'd4
    } state_t;

    localparam logic [6:0] HI_THRESH             = 7'd100;
    localparam logic [6:0] LO_THRESH             = 7'd10;
    localparam int         DEFAULT_UPDATE_PERIOD = 1200;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; done flags the final counted cycle (count <= 1).
module gate_timer #(
    parameter int BITS = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            dec,
    output logic            done
);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q <= BITS'(1));

endmodule

// File: rtl/freq_gate_controller.sv
// Measurement-window sequencer for the frequency counter: loadable gate period,
// result wait with timeout, and optional auto-ranging enabled by FREQ_AUTORANGE_EN.
module freq_gate_controller
    import freq_counter_pkg::*;
#(
    parameter int BITS           = 12,
    parameter int UPDATE_PERIOD  = DEFAULT_UPDATE_PERIOD,
    parameter int NUM_RANGES     = 4,
    parameter int RESULT_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [BITS-1:0] period_in,
    input  logic            period_load,
    input  logic [6:0]      edge_count,
    input  logic            count_valid,
    output logic [BITS-1:0] period,
    output logic            gate,
    output logic            start,
    output logic [1:0]      range,
    output logic            over_range,
    output logic            timeout_err
);

    localparam logic [1:0] MAX_RANGE = 2'(NUM_RANGES - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] base_q, base_d;
    logic [BITS-1:0] period_q, period_d;
    logic [1:0]      range_q, range_d;
    logic            over_range_q, over_range_d;
    logic            timeout_err_q, timeout_err_d;
    logic [6:0]      result_q, result_d;
    logic            first_q, first_d;

    logic [BITS-1:0] base_eff;
    logic [BITS-1:0] shifted;
    logic [BITS-1:0] eff_period;
    logic [1:0]      shift;
    logic            win_done;
    logic            to_done;

    // A load strobe coinciding with LOAD must already affect this window.
    always_comb begin
        base_eff   = period_load ? period_in : base_q;
        shift      = (range_q > MAX_RANGE) ? MAX_RANGE : range_q;
        shifted    = base_eff >> shift;
        eff_period = (shifted == '0) ? BITS'(1) : shifted;
    end

    gate_timer #(.BITS(BITS)) u_window (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == LOAD),
        .load_val (eff_period),
        .dec      (state_q == GATE),
        .done     (win_done)
    );

    // Re-armed in every state except WAIT, so each WAIT gets the full budget.
    gate_timer #(.BITS(BITS)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q != WAIT),
        .load_val (BITS'(RESULT_TIMEOUT)),
        .dec      (state_q == WAIT),
        .done     (to_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= BITS'(UPDATE_PERIOD);
            period_q      <= BITS'(UPDATE_PERIOD);
            range_q       <= 2'd0;
            over_range_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            result_q      <= 7'd0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            period_q      <= period_d;
            range_q       <= range_d;
            over_range_q  <= over_range_d;
            timeout_err_q <= timeout_err_d;
            result_q      <= result_d;
            first_q       <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable) state_d = LOAD;
            LOAD: state_d = GATE;
            GATE: if (win_done) state_d = WAIT;
            WAIT: begin
                if (count_valid) begin
                    state_d = EVAL;
                end else if (to_done) begin
                    state_d = enable ? LOAD : IDLE;
                end
            end
            EVAL: state_d = enable ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d        = period_load ? period_in : base_q;
        period_d      = (state_q == LOAD) ? eff_period : period_q;
        result_d      = ((state_q == WAIT) && count_valid) ? edge_count : result_q;
        first_d       = (state_q == LOAD);
        timeout_err_d = timeout_err_q |
                        ((state_q == WAIT) && !count_valid && to_done);
        range_d       = range_q;
        over_range_d  = over_range_q;
        if (state_q == EVAL) begin
`ifdef FREQ_AUTORANGE_EN
            over_range_d = (result_q >= HI_THRESH) && (range_q == MAX_RANGE);
            if ((result_q >= HI_THRESH) && (range_q < MAX_RANGE)) begin
                range_d = range_q + 2'd1;
            end else if ((result_q < LO_THRESH) && (range_q != 2'd0)) begin
                range_d = range_q - 2'd1;
            end
`else
            over_range_d = (result_q >= HI_THRESH);
`endif
        end
    end

    always_comb begin
        gate        = (state_q == GATE);
        start       = (state_q == GATE) && first_q;
        period      = period_q;
        range       = range_q;
        over_range  = over_range_q;
        timeout_err = timeout_err_q;
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller: window table plus reset/timeout/enable sequences.
module tb_freq_gate_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] period_in;
    logic        period_load;
    logic [6:0]  edge_count;
    logic        count_valid;
    logic [11:0] period;
    logic        gate;
    logic        start;
    logic [1:0]  range;
    logic        over_range;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    freq_gate_controller dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period_in   (period_in),
        .period_load (period_load),
        .edge_count  (edge_count),
        .count_valid (count_valid),
        .period      (period),
        .gate        (gate),
        .start       (start),
        .range       (range),
        .over_range  (over_range),
        .timeout_err (timeout_err)
    );

    typedef struct {
        bit          do_load;
        logic [11:0] load_val;
        logic [6:0]  ec;
        logic [11:0] exp_period;
        logic [1:0]  exp_range;
        logic        exp_over;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        period_in   = 12'd0;
        period_load = 1'b0;
        edge_count  = 7'd0;
        count_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits for start, measures the gate, then optionally answers with count_valid.
    // Returns at the first WAIT cycle (no response) or the cycle after EVAL.
    task automatic do_window(input string tag, input int exp_wait, input logic [11:0] exp_period,
                             input bit do_load, input logic [11:0] load_val, input bit drop_en,
                             input bit respond, input logic [6:0] ec,
                             input logic [1:0] exp_range, input logic exp_over);
        int n = 0;
        int len = 0;
        int starts = 0;
        int pbad = 0;
        while (!start && n < 100) begin
            tick();
            n++;
        end
        if (!start) begin
            check({tag, "_start_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, n, exp_wait);
        check({tag, "_period"}, period, exp_period);
        while (gate && len < 5000) begin
            if (start) starts++;
            if (period != exp_period) pbad++;
            len++;
            period_load = do_load && (len == 10);
            period_in   = load_val;
            if (drop_en && len == 5) enable = 1'b0;
            tick();
        end
        period_load = 1'b0;
        check({tag, "_gate_len"}, len, exp_period);
        check({tag, "_start_pulses"}, starts, 1);
        check({tag, "_period_stable"}, pbad, 0);
        if (respond) begin
            count_valid = 1'b1;
            edge_count  = ec;
            tick();
            count_valid = 1'b0;
            tick();
            check({tag, "_range"}, range, exp_range);
            check({tag, "_over_range"}, over_range, exp_over);
        end
        $display("window %s: len=%0d period=%0d range=%0d over=%0d", tag, len, period, range, over_range);
    endtask

    initial begin
        int k;
        int highs;

`ifdef FREQ_AUTORANGE_EN
        vecs.push_back('{1'b0, 12'd0,  7'd120, 12'd1200, 2'd1, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd120, 12'd600,  2'd2, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd120, 12'd300,  2'd3, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd120, 12'd150,  2'd3, 1'b1});
        vecs.push_back('{1'b0, 12'd0,  7'd5,   12'd150,  2'd2, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd10,  12'd300,  2'd2, 1'b0});
        vecs.push_back('{1'b1, 12'd50, 7'd9,   12'd300,  2'd1, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd100, 12'd25,   2'd2, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd99,  12'd12,   2'd2, 1'b0});
`else
        vecs.push_back('{1'b0, 12'd0,  7'd50,  12'd1200, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 12'd50, 7'd120, 12'd1200, 2'd0, 1'b1});
        vecs.push_back('{1'b0, 12'd0,  7'd120, 12'd50,   2'd0, 1'b1});
        vecs.push_back('{1'b0, 12'd0,  7'd5,   12'd50,   2'd0, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd99,  12'd50,   2'd0, 1'b0});
        vecs.push_back('{1'b0, 12'd0,  7'd100, 12'd50,   2'd0, 1'b1});
`endif

        // Reset state
        do_reset();
        check("rst_gate", gate, 0);
        check("rst_start", start, 0);
        check("rst_period", period, 1200);
        check("rst_range", range, 0);
        check("rst_over_range", over_range, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Back-to-back windows from the table
        enable = 1'b1;
        foreach (vecs[i]) begin
            do_window($sformatf("vec%0d", i), (i == 0) ? 2 : 1, vecs[i].exp_period,
                      vecs[i].do_load, vecs[i].load_val, 1'b0, 1'b1, vecs[i].ec,
                      vecs[i].exp_range, vecs[i].exp_over);
        end

        // Reset in the middle of a gate window
        k = 0;
        while (!start && k < 100) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check("midgate_gate_before", gate, 1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("midgate_gate_async", gate, 0);
        check("midgate_start_async", start, 0);
        tick();
        reset = 1'b0;
        tick();
        check("midgate_period", period, 1200);
        check("midgate_range", range, 0);
        $display("reset mid-gate: gate=%0d period=%0d range=%0d", gate, period, range);

        // Base load outside LOAD must not change the effective period
        period_in   = 12'd20;
        period_load = 1'b1;
        tick();
        period_load = 1'b0;
        check("idle_load_period_hold", period, 1200);

        // Result timeout
        enable = 1'b1;
        do_window("to_win", 2, 12'd20, 1'b0, 12'd0, 1'b0, 1'b0, 7'd0, 2'd0, 1'b0);
        check("to_not_yet", timeout_err, 0);
        k = 0;
        while (!timeout_err && k < 40) begin
            tick();
            k++;
        end
        check("to_cycles", k, 16);
        do_window("after_to", 1, 12'd20, 1'b0, 12'd0, 1'b0, 1'b1, 7'd50, 2'd0, 1'b0);
        check("to_sticky", timeout_err, 1);
        $display("timeout: cycles=%0d timeout_err=%0d", k, timeout_err);

        // Enable dropped mid-window: window and EVAL complete, then idle
        do_window("drop_en", 1, 12'd20, 1'b0, 12'd0, 1'b1, 1'b1, 7'd50, 2'd0, 1'b0);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            if (gate) highs++;
            tick();
        end
        check("idle_no_gate", highs, 0);

        // Zero period clamps to a single gate cycle
        period_in   = 12'd0;
        period_load = 1'b1;
        tick();
        period_load = 1'b0;
        enable      = 1'b1;
        do_window("clamp", 2, 12'd1, 1'b0, 12'd0, 1'b0, 1'b1, 7'd50, 2'd0, 1'b0);
        check("clamp_to_sticky", timeout_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
